// File: rtl/gray_unpack_pkg.sv
// Shared types and constants for the gray-nibble unpacker.
package gray_unpack_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EMIT_HI,
    EMIT_LO
  } state_t;

  localparam int DEF_H_RES = 160;
  localparam int DEF_V_RES = 120;
  localparam int PIX_W     = 12;

  // A 4-bit gray sample is replicated into all three RGB444 channels.
  function automatic logic [PIX_W-1:0] gray3(input logic [3:0] g);
    return {g, g, g};
  endfunction

endpackage

// File: rtl/gray_hold_buf.sv
// One-entry holding register with full flag; reports a byte dropped when full and not draining.
module gray_hold_buf (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic       full,
  output logic [7:0] dout,
  output logic       drop
);

  assign drop = push & full & ~pop & ~clear;

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      dout <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (push && (!full || pop)) begin
      // A pop in the same cycle reads the old entry before it is replaced.
      dout <= din;
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/gray_unpack.sv
// Unpacks UART bytes (two 4-bit gray samples each) into a valid/ready RGB444 pixel stream.
// Optional GRAY_DROP_CNT_EN adds a saturating dropped-byte counter output drop_cnt.
module gray_unpack
  import gray_unpack_pkg::*;
#(
  parameter int H_RES = DEF_H_RES,
  parameter int V_RES = DEF_V_RES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [PIX_W-1:0]         pixel_data,
  output logic                     pixel_valid,
  input  logic                     pixel_ready,
  output logic [$clog2(H_RES)-1:0] pixel_x,
  output logic [$clog2(V_RES)-1:0] pixel_y,
  output logic                     frame_done,
  output logic                     overflow
`ifdef GRAY_DROP_CNT_EN
  ,
  output logic [7:0]               drop_cnt
`endif
);

  localparam int unsigned XW = $clog2(H_RES);
  localparam int unsigned YW = $clog2(V_RES);

  state_t     state, state_nx;
  logic [7:0] cur_byte;
  logic       hs, last_pix, x_last;
  logic       hold_full, hold_drop, hold_push, hold_pop, hold_clear;
  logic [7:0] hold_data;
  logic       load_cur;
  logic [7:0] load_src;

  assign pixel_valid = (state == EMIT_HI) || (state == EMIT_LO);
  assign hs          = pixel_valid & pixel_ready;
  assign x_last      = (pixel_x == XW'(H_RES - 1));
  assign last_pix    = x_last && (pixel_y == YW'(V_RES - 1));

  always_comb begin
    pixel_data = '0;
    if (state == EMIT_HI)      pixel_data = gray3(cur_byte[7:4]);
    else if (state == EMIT_LO) pixel_data = gray3(cur_byte[3:0]);
  end

  gray_hold_buf u_hold (
    .clk   (clk),
    .rst   (rst),
    .clear (hold_clear),
    .push  (hold_push),
    .pop   (hold_pop),
    .din   (rx_data),
    .full  (hold_full),
    .dout  (hold_data),
    .drop  (hold_drop)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    hold_push  = 1'b0;
    hold_pop   = 1'b0;
    hold_clear = 1'b0;
    load_cur   = 1'b0;
    load_src   = rx_data;
    if (frame_start) begin
      hold_clear = 1'b1;
      if (rx_valid) begin
        load_cur = 1'b1;
        state_nx = EMIT_HI;
      end else begin
        state_nx = LOAD;
      end
    end else begin
      unique case (state)
        IDLE: state_nx = IDLE;
        LOAD: begin
          // A byte parked during the last EMIT_LO handshake is served before new input.
          if (hold_full) begin
            load_cur  = 1'b1;
            load_src  = hold_data;
            hold_pop  = 1'b1;
            hold_push = rx_valid;
            state_nx  = EMIT_HI;
          end else if (rx_valid) begin
            load_cur = 1'b1;
            state_nx = EMIT_HI;
          end
        end
        EMIT_HI, EMIT_LO: begin
          hold_push = rx_valid;
          if (hs && last_pix) begin
            hold_clear = 1'b1;
            hold_push  = 1'b0;
            state_nx   = IDLE;
          end else if (hs && state == EMIT_HI) begin
            state_nx = EMIT_LO;
          end else if (hs) begin
            if (hold_full) begin
              load_cur = 1'b1;
              load_src = hold_data;
              hold_pop = 1'b1;
              state_nx = EMIT_HI;
            end else begin
              state_nx = LOAD;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_byte   <= '0;
      pixel_x    <= '0;
      pixel_y    <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (load_cur) cur_byte <= load_src;
      if (frame_start) begin
        pixel_x  <= '0;
        pixel_y  <= '0;
        overflow <= 1'b0;
      end else begin
        if (hold_drop) overflow <= 1'b1;
        if (hs) begin
          if (last_pix) begin
            pixel_x    <= '0;
            pixel_y    <= '0;
            frame_done <= 1'b1;
          end else if (x_last) begin
            pixel_x <= '0;
            pixel_y <= pixel_y + YW'(1);
          end else begin
            pixel_x <= pixel_x + XW'(1);
          end
        end
      end
    end
  end

`ifdef GRAY_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || frame_start)                 drop_cnt <= '0;
    else if (hold_drop && drop_cnt != '1)   drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule

// File: doc/gray_unpack.md
GRAY_UNPACK -- requirements
Module: gray_unpack

Interface
REQ-001 The block SHALL have parameter H_RES, default 160, giving pixels per line.
REQ-002 The block SHALL have parameter V_RES, default 120, giving lines per frame.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 frame_start  input  1  one-cycle pulse from the UART link layer marking the start of a frame.
REQ-006 rx_data  input  8  received byte holding two 4-bit gray samples, high nibble first.
REQ-007 rx_valid  input  1  rx_data valid this cycle; no backpressure toward the receiver.
REQ-008 pixel_data  output  12  RGB444 pixel {g,g,g}.
REQ-009 pixel_valid  output  1  pixel_data valid.
REQ-010 pixel_ready  input  1  downstream accepts the pixel when pixel_valid and pixel_ready are both high.
REQ-011 pixel_x  output  log2(H_RES)  column of the current pixel.
REQ-012 pixel_y  output  log2(V_RES)  line of the current pixel.
REQ-013 frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.
REQ-014 overflow  output  1  sticky flag: a byte was dropped; cleared by rst or frame_start.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, EMIT_HI and EMIT_LO.
REQ-016 IDLE SHALL ignore rx_valid and SHALL go to LOAD on frame_start.
REQ-017 In LOAD, an rx_valid byte SHALL be captured and the FSM SHALL go to EMIT_HI; pixel_valid SHALL rise on the next cycle (1-cycle latency).
REQ-018 EMIT_HI SHALL present {rx[7:4] x3}; on handshake the FSM SHALL go to EMIT_LO presenting {rx[3:0] x3}.
REQ-019 On EMIT_LO handshake, the FSM SHALL go to EMIT_HI if the hold register is full (consuming it), else to LOAD.
REQ-020 pixel_data, pixel_x and pixel_y SHALL remain stable while pixel_valid is high and pixel_ready is low.
REQ-021 A byte arriving in EMIT_HI/EMIT_LO SHALL be stored in a 1-entry hold register; if the hold register is already full and not emptying that cycle, the byte SHALL be dropped and overflow set.
REQ-022 pixel_x SHALL increment on each handshake and wrap H_RES-1 to 0, incrementing pixel_y.
REQ-023 The handshake at (H_RES-1, V_RES-1) SHALL pulse frame_done the next cycle, go to IDLE, clear the hold register and reset the counters to 0.
REQ-024 frame_start in any non-IDLE state SHALL abort the frame: pixel_valid low, hold cleared, counters 0, state LOAD, and no frame_done.
REQ-025 When frame_start and rx_valid occur in the same cycle, the byte SHALL be captured as the first byte of the new frame.

Reset
REQ-026 rst SHALL force state IDLE, pixel_data 12'h000, pixel_valid 0, pixel_x 0, pixel_y 0, frame_done 0, overflow 0 and hold empty.
REQ-027 rst SHALL take priority over frame_start and rx_valid in the same cycle.

Configuration
REQ-028 With GRAY_DROP_CNT_EN defined, the block SHALL add output drop_cnt[7:0], counting dropped bytes, saturating at 255, cleared by rst or frame_start.
REQ-029 Without GRAY_DROP_CNT_EN, drop_cnt and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, the default H_RES/V_RES constants and the RGB444 pixel width (12).
REQ-031 The 1-entry hold register with its full flag SHALL be a sub-module, gray_hold_buf.

Verification
REQ-032 rst, frame_start, rx byte 8'h3C, pixel_ready=1 -> pixel_data 12'h333 at x=0 then 12'hCCC at x=1, one cycle each.
REQ-033 Byte 8'hA5 with pixel_ready held low 5 cycles -> 12'hAAA stays stable for 5 cycles; 12'h555 follows after ready rises.
REQ-034 Three bytes on consecutive cycles with pixel_ready=0 -> byte 2 held, byte 3 dropped, overflow=1, drop_cnt=1 if enabled.
REQ-035 H_RES=4, V_RES=2, 4 bytes streamed -> x wraps 3 to 0, y goes 0 to 1, frame_done pulses once after the 8th pixel, state returns to IDLE.
REQ-036 frame_start after 3 pixels together with byte 8'h7E -> next pixels are 12'h777 at (0,0) then 12'hEEE at (1,0), no frame_done.
REQ-037 rst asserted mid-EMIT_LO -> all outputs at their reset values next cycle; rx_valid is ignored until the next frame_start.
